instr_fetch_mem: RTL and testbench

Parametrised, writable instruction memory with a registered fetch port and a valid/ready handshake. It replaces the fixed combinational program ROM.
- After reset, a hardware init walker fills every word with NOP_WORD. Programs are then loaded through a dedicated write port.
- Sits between the PC/fetch stage and decode. One read per cycle, 1-cycle read latency, back-pressure from decode.

---
 rtl/fetch_pkg.sv | 17 +
 rtl/imem_array.sv | 46 ++++
 rtl/instr_fetch_mem.sv | 130 +++++++++++++
 tb/tb_instr_fetch_mem.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
`default_nettype none
// ==========================================================================
// Module : fetch_pkg
// Desc   : Fetch-stage FSM states and the shared NOP encoding.
// Rev    : 1.0 - initial release
// ==========================================================================
package fetch_pkg;

   typedef enum logic [0:0] {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } fetch_state_e;

   localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0000;

endpackage
`default_nettype wire

// File: rtl/imem_array.sv
`default_nettype none
// ==========================================================================
// Module : imem_array
// Desc   : 1W/1R synchronous RAM, registered read with write-first bypass.
// Rev    : 1.0 - initial release
// ==========================================================================
module imem_array
   import fetch_pkg::*;
#(
   parameter int ADDR_W = 6,
   parameter int DATA_W = 32,
   parameter int DEPTH  = 64
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   localparam int c_idx_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DATA_W-1:0]  r_mem [DEPTH];
   logic [DATA_W-1:0]  r_rdata;
   logic [c_idx_w-1:0] w_widx;
   logic [c_idx_w-1:0] w_ridx;

   // Callers keep both addresses below DEPTH, so truncation is lossless.
   assign w_widx = waddr[c_idx_w-1:0];
   assign w_ridx = raddr[c_idx_w-1:0];

   always_ff @(posedge clk) begin
      if (we) begin
         r_mem[w_widx] <= wdata;
      end
      if (re) begin
         r_rdata <= (we && (waddr == raddr)) ? wdata : r_mem[w_ridx];
      end
   end

   assign rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/instr_fetch_mem.sv
`default_nettype none
// ==========================================================================
// Module : instr_fetch_mem
// Desc   : Writable instruction memory, init walker, valid/ready fetch port.
// Rev    : 1.0 - initial release
// ==========================================================================
module instr_fetch_mem
   import fetch_pkg::*;
#(
   parameter int                ADDR_W   = 6,
   parameter int                DATA_W   = 32,
   parameter int                DEPTH    = 64,
   parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(NOP_WORD_DEFAULT)
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic              init_done,
   input  logic              load_en,
   input  logic [ADDR_W-1:0] load_addr,
   input  logic [DATA_W-1:0] load_data,
   output logic              load_gnt,
   output logic              load_oob,
   input  logic              fetch_req,
   input  logic [ADDR_W-1:0] fetch_addr,
   output logic              fetch_gnt,
   output logic              instr_valid,
   input  logic              instr_ready,
   output logic [DATA_W-1:0] instr_out,
   output logic [ADDR_W-1:0] instr_addr
);

   localparam int                c_ptr_w = $clog2(DEPTH) + 1;
   localparam logic [c_ptr_w-1:0] c_last  = c_ptr_w'(DEPTH - 1);
   localparam logic [ADDR_W:0]    c_depth = (ADDR_W + 1)'(DEPTH);

   fetch_state_e         r_state;
   logic [c_ptr_w-1:0]   r_init_ptr;
   logic                 r_init_done;
   logic                 r_load_oob;
   logic                 r_valid;
   logic [ADDR_W-1:0]    r_addr;
   logic                 r_nop;

   logic                 w_load_oob;
   logic                 w_fetch_oob;
   logic                 w_load_wr;
   logic                 w_accept;
   logic                 w_we;
   logic [ADDR_W-1:0]    w_waddr;
   logic [DATA_W-1:0]    w_wdata;
   logic                 w_re;
   logic [DATA_W-1:0]    w_rdata;

   assign w_load_oob  = {1'b0, load_addr}  >= c_depth;
   assign w_fetch_oob = {1'b0, fetch_addr} >= c_depth;
   assign w_load_wr   = load_en && r_init_done;
   assign w_accept    = fetch_req && fetch_gnt;

   // The init walker owns the write port until RUN; loads take it afterwards.
   assign w_we    = (r_state == ST_INIT) || (w_load_wr && !w_load_oob);
   assign w_waddr = (r_state == ST_INIT) ? ADDR_W'(r_init_ptr) : load_addr;
   assign w_wdata = (r_state == ST_INIT) ? NOP_WORD : load_data;
   assign w_re    = w_accept && !w_fetch_oob;

   imem_array #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_imem (
      .clk   (clk),
      .we    (w_we),
      .waddr (w_waddr),
      .wdata (w_wdata),
      .re    (w_re),
      .raddr (fetch_addr),
      .rdata (w_rdata)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_INIT;
         r_init_ptr  <= '0;
         r_init_done <= 1'b0;
      end else begin
         case (r_state)
            ST_INIT: begin
               if (r_init_ptr == c_last) begin
                  r_state     <= ST_RUN;
                  r_init_done <= 1'b1;
               end else begin
                  r_init_ptr <= r_init_ptr + 1'b1;
               end
            end
            ST_RUN:  r_state <= ST_RUN;
            default: r_state <= ST_INIT;
         endcase
      end
   end

   // RAM read data only changes on accept, so a stalled response is a snapshot.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid    <= 1'b0;
         r_addr     <= '0;
         r_nop      <= 1'b1;
         r_load_oob <= 1'b0;
      end else begin
         if (w_accept) begin
            r_valid <= 1'b1;
            r_addr  <= fetch_addr;
            r_nop   <= w_fetch_oob;
         end else if (r_valid && instr_ready) begin
            r_valid <= 1'b0;
         end
         if (w_load_wr && w_load_oob) begin
            r_load_oob <= 1'b1;
         end
      end
   end

   assign init_done   = r_init_done;
   assign load_gnt    = r_init_done;
   assign load_oob    = r_load_oob;
   assign fetch_gnt   = r_init_done && (!r_valid || instr_ready);
   assign instr_valid = r_valid;
   assign instr_addr  = r_addr;
   assign instr_out   = r_nop ? NOP_WORD : w_rdata;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_mem.sv
`default_nettype none
// ==========================================================================
// Module : tb_instr_fetch_mem
// Desc   : Directed bench for instr_fetch_mem at DEPTH=64 and DEPTH=40.
// Rev    : 1.0 - initial release
// ==========================================================================
module tb_instr_fetch_mem;

   logic        clk;
   logic        rst_n;
   logic        load_en;
   logic [5:0]  load_addr;
   logic [31:0] load_data;
   logic        fetch_req;
   logic [5:0]  fetch_addr;
   logic        instr_ready;

   logic        a_init_done, a_load_gnt, a_load_oob, a_fetch_gnt, a_valid;
   logic [31:0] a_out;
   logic [5:0]  a_addr;
   logic        b_init_done, b_load_gnt, b_load_oob, b_fetch_gnt, b_valid;
   logic [31:0] b_out;
   logic [5:0]  b_addr;

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      logic        ld;
      logic [5:0]  la;
      logic [31:0] ldat;
      logic        fr;
      logic [5:0]  fa;
      logic        rdy;
      logic        gnt;
      logic        val;
      logic [31:0] out;
      logic [5:0]  addr;
   } vec_t;

   vec_t tbl [13];

   instr_fetch_mem #(.ADDR_W(6), .DATA_W(32), .DEPTH(64), .NOP_WORD(32'h0)) dut (
      .clk(clk), .rst_n(rst_n), .init_done(a_init_done),
      .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
      .load_gnt(a_load_gnt), .load_oob(a_load_oob),
      .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(a_fetch_gnt),
      .instr_valid(a_valid), .instr_ready(instr_ready),
      .instr_out(a_out), .instr_addr(a_addr)
   );

   instr_fetch_mem #(.ADDR_W(6), .DATA_W(32), .DEPTH(40), .NOP_WORD(32'h0)) dut40 (
      .clk(clk), .rst_n(rst_n), .init_done(b_init_done),
      .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
      .load_gnt(b_load_gnt), .load_oob(b_load_oob),
      .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(b_fetch_gnt),
      .instr_valid(b_valid), .instr_ready(instr_ready),
      .instr_out(b_out), .instr_addr(b_addr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      load_en   = 1'b0;
      load_addr = '0;
      load_data = '0;
      fetch_req = 1'b0;
      fetch_addr = '0;
   endtask

   task automatic apply(input vec_t v, input int i);
      load_en     = v.ld;
      load_addr   = v.la;
      load_data   = v.ldat;
      fetch_req   = v.fr;
      fetch_addr  = v.fa;
      instr_ready = v.rdy;
      #1;
      chk($sformatf("v%0d gnt64", i), 32'(a_fetch_gnt), 32'(v.gnt));
      chk($sformatf("v%0d gnt40", i), 32'(b_fetch_gnt), 32'(v.gnt));
      tick();
      chk($sformatf("v%0d valid64", i), 32'(a_valid), 32'(v.val));
      chk($sformatf("v%0d out64", i), a_out, v.out);
      chk($sformatf("v%0d addr64", i), 32'(a_addr), 32'(v.addr));
      chk($sformatf("v%0d valid40", i), 32'(b_valid), 32'(v.val));
      chk($sformatf("v%0d out40", i), b_out, v.out);
      chk($sformatf("v%0d addr40", i), 32'(b_addr), 32'(v.addr));
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, " valid64"}, 32'(a_valid), 32'd0);
      chk({tag, " out64"}, a_out, 32'h0);
      chk({tag, " addr64"}, 32'(a_addr), 32'd0);
      chk({tag, " done64"}, 32'(a_init_done), 32'd0);
      chk({tag, " fgnt64"}, 32'(a_fetch_gnt), 32'd0);
      chk({tag, " lgnt64"}, 32'(a_load_gnt), 32'd0);
      chk({tag, " oob40"}, 32'(b_load_oob), 32'd0);
      chk({tag, " done40"}, 32'(b_init_done), 32'd0);
   endtask

   initial begin
      int c64;
      int c40;

      //              ld    la     ldat          fr    fa     rdy   gnt   val   out           addr
      tbl[0]  = '{1'b1, 6'd6,  32'h13F00001, 1'b0, 6'd0,  1'b1, 1'b1, 1'b0, 32'h00000000, 6'd63};
      tbl[1]  = '{1'b1, 6'd7,  32'h17F10062, 1'b0, 6'd0,  1'b1, 1'b1, 1'b0, 32'h00000000, 6'd63};
      tbl[2]  = '{1'b0, 6'd0,  32'h0,        1'b1, 6'd6,  1'b1, 1'b1, 1'b1, 32'h13F00001, 6'd6};
      tbl[3]  = '{1'b0, 6'd0,  32'h0,        1'b1, 6'd7,  1'b1, 1'b1, 1'b1, 32'h17F10062, 6'd7};
      tbl[4]  = '{1'b0, 6'd0,  32'h0,        1'b0, 6'd0,  1'b1, 1'b1, 1'b0, 32'h17F10062, 6'd7};
      tbl[5]  = '{1'b0, 6'd0,  32'h0,        1'b1, 6'd6,  1'b1, 1'b1, 1'b1, 32'h13F00001, 6'd6};
      tbl[6]  = '{1'b1, 6'd6,  32'hDEADBEEF, 1'b1, 6'd7,  1'b0, 1'b0, 1'b1, 32'h13F00001, 6'd6};
      tbl[7]  = '{1'b0, 6'd0,  32'h0,        1'b1, 6'd7,  1'b0, 1'b0, 1'b1, 32'h13F00001, 6'd6};
      tbl[8]  = '{1'b0, 6'd0,  32'h0,        1'b0, 6'd0,  1'b0, 1'b0, 1'b1, 32'h13F00001, 6'd6};
      tbl[9]  = '{1'b0, 6'd0,  32'h0,        1'b0, 6'd0,  1'b1, 1'b1, 1'b0, 32'h13F00001, 6'd6};
      tbl[10] = '{1'b0, 6'd0,  32'h0,        1'b1, 6'd6,  1'b1, 1'b1, 1'b1, 32'hDEADBEEF, 6'd6};
      tbl[11] = '{1'b1, 6'd10, 32'h13F40272, 1'b1, 6'd10, 1'b1, 1'b1, 1'b1, 32'h13F40272, 6'd10};
      tbl[12] = '{1'b0, 6'd0,  32'h0,        1'b0, 6'd0,  1'b1, 1'b1, 1'b0, 32'h13F40272, 6'd10};

      rst_n = 1'b0;
      instr_ready = 1'b1;
      idle();
      repeat (3) tick();
      chk_reset_outputs("reset");
      rst_n = 1'b1;

      // INIT: requests are presented but must be ignored by both instances.
      for (int c = 1; c <= 64; c++) begin
         if (c <= 39) begin
            load_en = 1'b1; load_addr = 6'd50; load_data = 32'h11111111;
            fetch_req = 1'b1; fetch_addr = 6'd5;
         end else begin
            idle();
         end
         #1;
         chk($sformatf("init c%0d fgnt64", c), 32'(a_fetch_gnt), 32'd0);
         chk($sformatf("init c%0d lgnt64", c), 32'(a_load_gnt), 32'd0);
         if (c <= 39) begin
            chk($sformatf("init c%0d fgnt40", c), 32'(b_fetch_gnt), 32'd0);
         end
         tick();
         if (c == 39 || c == 40) chk($sformatf("done40 c%0d", c), 32'(b_init_done), 32'(c == 40));
         if (c == 63 || c == 64) chk($sformatf("done64 c%0d", c), 32'(a_init_done), 32'(c == 64));
      end
      chk("init valid64", 32'(a_valid), 32'd0);
      chk("init oob40", 32'(b_load_oob), 32'd0);

      // Every word reads back as the NOP fill, one response per cycle.
      for (int a = 0; a < 64; a++) begin
         fetch_req = 1'b1;
         fetch_addr = 6'(a);
         instr_ready = 1'b1;
         #1;
         chk($sformatf("sweep %0d gnt", a), 32'(a_fetch_gnt), 32'd1);
         tick();
         chk($sformatf("sweep %0d valid", a), 32'(a_valid), 32'd1);
         chk($sformatf("sweep %0d out64", a), a_out, 32'h0);
         chk($sformatf("sweep %0d out40", a), b_out, 32'h0);
         chk($sformatf("sweep %0d addr", a), 32'(a_addr), 32'(a));
      end

      foreach (tbl[i]) apply(tbl[i], i);
      idle();

      // Out-of-range write on the 40-word instance.
      load_en = 1'b1; load_addr = 6'd50; load_data = 32'hCAFEBABE;
      #1;
      chk("oob40 before", 32'(b_load_oob), 32'd0);
      tick();
      idle();
      chk("oob40 set", 32'(b_load_oob), 32'd1);
      chk("oob64 clear", 32'(a_load_oob), 32'd0);
      fetch_req = 1'b1; fetch_addr = 6'd50;
      tick();
      chk("oob fetch valid40", 32'(b_valid), 32'd1);
      chk("oob fetch out40", b_out, 32'h0);
      chk("oob fetch addr40", 32'(b_addr), 32'd50);
      chk("oob fetch out64", a_out, 32'hCAFEBABE);
      fetch_addr = 6'd10;
      tick();
      chk("alias out40", b_out, 32'h13F40272);
      chk("oob sticky40", 32'(b_load_oob), 32'd1);
      idle();
      tick();

      // Reset during a stalled fetch.
      fetch_req = 1'b1; fetch_addr = 6'd6; instr_ready = 1'b0;
      tick();
      idle();
      chk("stall out64", a_out, 32'hDEADBEEF);
      tick();
      #2 rst_n = 1'b0;
      #1;
      chk_reset_outputs("midstall");
      @(posedge clk);
      #1 rst_n = 1'b1;
      instr_ready = 1'b1;
      repeat (20) tick();
      chk("midinit done64", 32'(a_init_done), 32'd0);
      #2 rst_n = 1'b0;
      #1;
      chk_reset_outputs("midinit");
      @(posedge clk);
      #1 rst_n = 1'b1;

      c64 = -1;
      c40 = -1;
      for (int n = 1; n <= 200; n++) begin
         tick();
         if (c40 < 0 && b_init_done) c40 = n;
         if (c64 < 0 && a_init_done) c64 = n;
         if (c40 >= 0 && c64 >= 0) break;
      end
      chk("reinit cycles64", 32'(c64), 32'd64);
      chk("reinit cycles40", 32'(c40), 32'd40);

      fetch_req = 1'b1; fetch_addr = 6'd6;
      tick();
      idle();
      chk("reinit fetch out64", a_out, 32'h0);
      chk("reinit fetch valid64", 32'(a_valid), 32'd1);
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
